// File: rtl/aes_inv_subbytes_seq_if.sv
// Handshake bundle for aes_inv_subbytes_seq.
// Both directions use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high; once raised, valid and its data hold
// until that edge.
// dbg_state mirrors the engine FSM (0 IDLE, 1 RUN, 2 DONE) for checkers.
interface aes_inv_subbytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   dbg_state;

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state, busy, dbg_state
  );

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy, dbg_state
  );
endinterface

// File: rtl/aes_inv_subbytes_seq.sv
// Iterative AES InvSubBytes engine: LANES shared inverse S-boxes walk the
// 16 state bytes one chunk per cycle, low chunk first.
// Optional feature: define AES_INV_SUBBYTES_PIPE_EN to register the S-box
// outputs (and their chunk index) before write-back, adding one cycle.
module aes_inv_subbytes_seq #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  aes_inv_subbytes_seq_if.slave bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = LANES * 8;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [127:0]  work;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [BW-1:0] rd_chunk;
  logic [BW-1:0] sbox_out;

  // Substitute the chunk selected by the counter through the shared S-boxes.
  always_comb begin
    rd_chunk = work[int'(cnt) * BW +: BW];
    sbox_out = '0;
    for (int l = 0; l < LANES; l++) begin
      sbox_out[l*8 +: 8] = INV_SBOX[rd_chunk[l*8 +: 8]];
    end
  end

`ifdef AES_INV_SUBBYTES_PIPE_EN
  logic [BW-1:0] pipe_q;
  logic [CW-1:0] pipe_idx;
  logic          pipe_full;
  logic          wr_en;
  logic          wr_last;
  logic [CW-1:0] wr_idx;
  logic [BW-1:0] wr_data;

  // Pipe stage: capture S-box outputs and their chunk index every RUN cycle;
  // it empties once the last chunk has been written back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q    <= '0;
      pipe_idx  <= '0;
      pipe_full <= 1'b0;
    end else begin
      pipe_q    <= sbox_out;
      pipe_idx  <= cnt;
      pipe_full <= (state == RUN) && !wr_last;
    end
  end

  assign wr_en   = pipe_full;
  assign wr_last = pipe_full && (pipe_idx == LAST);
  assign wr_idx  = pipe_idx;
  assign wr_data = pipe_q;
`else
  logic          wr_en;
  logic          wr_last;
  logic [CW-1:0] wr_idx;
  logic [BW-1:0] wr_data;

  assign wr_en   = 1'b1;
  assign wr_last = (cnt == LAST);
  assign wr_idx  = cnt;
  assign wr_data = sbox_out;
`endif

  // Engine FSM: accept in IDLE, write back one chunk per RUN cycle, hold the
  // result in DONE until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      work        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work       <= bus.in_state;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (wr_en) begin
            work[int'(wr_idx) * BW +: BW] <= wr_data;
          end
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (wr_last) begin
            cnt         <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = work;
  assign bus.busy      = busy_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Bench for aes_inv_subbytes_seq: LANES=4 main instance plus LANES=16 and
// LANES=1 instances. The reference inverse S-box is derived from GF(2^8)
// inversion and the forward affine map, then inverted as a lookup.
module tb_aes_inv_subbytes_seq;

`ifdef AES_INV_SUBBYTES_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [7:0] inv_tab [256];

  aes_inv_subbytes_seq_if bus4 ();
  aes_inv_subbytes_seq_if bus16 ();
  aes_inv_subbytes_seq_if bus1 ();

  aes_inv_subbytes_seq #(.LANES(4))  u_dut   (.clk(clk), .reset(reset), .bus(bus4));
  aes_inv_subbytes_seq #(.LANES(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  aes_inv_subbytes_seq #(.LANES(1))  u_dut1  (.clk(clk), .reset(reset), .bus(bus1));

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} << n;
    return t[15:8];
  endfunction

  task automatic build_model();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_inv_sub(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[st[i*8 +: 8]];
    return r;
  endfunction

  // ---------------- scoreboard / checker ----------------
  logic [127:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  // One job on the LANES=4 instance; hold = cycles of out_ready low in DONE.
  task automatic run_job(input logic [127:0] st, input int hold, output logic [127:0] res);
    logic [127:0] exp;
    int lat;
    exp_q.push_back(ref_inv_sub(st));
    @(posedge clk); #1;
    check("idle_in_ready", bus4.in_ready, 1'b1);
    bus4.in_valid  = 1'b1;
    bus4.in_state  = st;
    bus4.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.in_state = rand_state();
    check("run_busy", bus4.busy, 1'b1);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (bus4.out_valid) lat = k;
    end
    check("latency", 128'(lat), 128'(4 + PIPE));
    exp = exp_q.pop_front();
    check("result", bus4.out_state, exp);
    res = bus4.out_state;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus4.in_valid = 1'b1;
        bus4.in_state = rand_state();
        @(posedge clk); #1;
        check("bp_stable", bus4.out_state, exp);
        check("bp_in_ready", bus4.in_ready, 1'b0);
        check("bp_out_valid", bus4.out_valid, 1'b1);
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      check("hs_in_ready", bus4.in_ready, 1'b1);
      check("hs_out_valid", bus4.out_valid, 1'b0);
      check("hs_not_captured", bus4.out_state, exp);
      @(posedge clk); #1;
      check("single_handshake", bus4.out_valid, 1'b0);
      check("no_capture_busy", bus4.busy, 1'b0);
      bus4.out_ready = 1'b0;
    end else begin
      @(posedge clk); #1;
      check("post_in_ready", bus4.in_ready, 1'b1);
      check("post_out_valid", bus4.out_valid, 1'b0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] res;
    logic [127:0] r16, r1;
    int l16, l1;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_state = '0;  bus4.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_state = '0; bus16.out_ready = 1'b0;
    bus1.in_valid = 1'b0;  bus1.in_state = '0;  bus1.out_ready = 1'b0;
    build_model();
    #1;
    check("rst_in_ready", bus4.in_ready, 1'b1);
    check("rst_out_valid", bus4.out_valid, 1'b0);
    check("rst_busy", bus4.busy, 1'b0);
    check("rst_out_state", bus4.out_state, 128'h0);
    check("rst_out_valid16", bus16.out_valid, 1'b0);
    check("rst_out_valid1", bus1.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All bytes 0x63 -> all zero.
    run_job({16{8'h63}}, 0, res);
    check("all63_const", res, 128'h0);

    // Bytes 0x00..0x0F.
    run_job(128'h0f0e0d0c0b0a09080706050403020100, 0, res);
    check("seq_const", res, 128'hfbd7f3819ea340bf38a53630d56a0952);

    // Back-pressure: 10 cycles of out_ready low with new data offered.
    run_job(rand_state(), 10, res);

    // Reset in the second RUN cycle.
    @(posedge clk); #1;
    bus4.in_valid  = 1'b1;
    bus4.in_state  = {16{8'hff}};
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", bus4.out_valid, 1'b0);
    check("mid_rst_out_state", bus4.out_state, 128'h0);
    check("mid_rst_busy", bus4.busy, 1'b0);
    check("mid_rst_in_ready", bus4.in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("discarded_job", bus4.out_valid, 1'b0);
    end
    run_job({16{8'hff}}, 0, res);
    check("allff_const", res, {16{8'h7d}});

    // Randomized jobs, back-to-back and with random back-pressure.
    for (int j = 0; j < 24; j++) begin
      run_job(rand_state(), (j % 2 == 0) ? 0 : int'($urandom_range(1, 3)), res);
    end

    // LANES=16 and LANES=1 instances, all bytes 0x01.
    @(posedge clk); #1;
    bus16.in_valid = 1'b1; bus16.in_state = {16{8'h01}}; bus16.out_ready = 1'b1;
    bus1.in_valid  = 1'b1; bus1.in_state  = {16{8'h01}}; bus1.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus1.in_valid  = 1'b0;
    l16 = 0; l1 = 0; r16 = '0; r1 = '0;
    for (int k = 1; k <= 40 && (l16 == 0 || l1 == 0); k++) begin
      @(posedge clk); #1;
      if (bus16.out_valid && l16 == 0) begin l16 = k; r16 = bus16.out_state; end
      if (bus1.out_valid && l1 == 0) begin l1 = k; r1 = bus1.out_state; end
    end
    check("lat_lanes16", 128'(l16), 128'(1 + PIPE));
    check("lat_lanes1", 128'(l1), 128'(16 + PIPE));
    check("res_lanes16", r16, {16{8'h09}});
    check("res_lanes1", r1, {16{8'h09}});
    check("model_lanes1", r1, ref_inv_sub({16{8'h01}}));
    @(posedge clk); #1;
    check("lanes16_idle", bus16.in_ready, 1'b1);
    check("lanes1_idle", bus1.in_ready, 1'b1);

    // Random states through the LANES=1 and LANES=16 instances.
    for (int j = 0; j < 4; j++) begin
      logic [127:0] st;
      st = rand_state();
      bus16.in_valid = 1'b1; bus16.in_state = st;
      bus1.in_valid  = 1'b1; bus1.in_state  = st;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      bus1.in_valid  = 1'b0;
      l16 = 0; l1 = 0;
      for (int k = 1; k <= 40 && (l16 == 0 || l1 == 0); k++) begin
        @(posedge clk); #1;
        if (bus16.out_valid && l16 == 0) begin l16 = k; r16 = bus16.out_state; end
        if (bus1.out_valid && l1 == 0) begin l1 = k; r1 = bus1.out_state; end
      end
      check("rand_lanes16", r16, ref_inv_sub(st));
      check("rand_lanes1", r1, ref_inv_sub(st));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
